// File: rtl/uart_echo_ctrl.sv
// Terminal echo engine: pops RX bytes, edits a local line buffer, echoes via UART TX.
// Optional build macro ECHO_UPCASE_EN folds a..z to A..Z before storing and echoing.
module uart_echo_ctrl #(
  parameter int max_line = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_get,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [7:0] line_len,
  output logic       line_done,
  input  logic [7:0] line_rd_addr,
  output logic [7:0] line_rd_data
);

  localparam int AW = $clog2(max_line);
  localparam logic [7:0] MAX = 8'(max_line);

  typedef enum logic [2:0] {IDLE, DECODE, EMIT, WAIT_ACK, WAIT_TX} state_t;

  state_t     state;
  logic [7:0] cur;
  logic [7:0] seq [0:3];
  logic [1:0] seq_len;
  logic [1:0] idx;
  logic [7:0] ram [0:max_line-1];

  logic [7:0] ch;
  logic       printable;
  logic       erase;
  logic       room;
  logic       store;

  always_comb begin
    ch = cur;
`ifdef ECHO_UPCASE_EN
    if (cur >= 8'h61 && cur <= 8'h7A) ch = cur - 8'h20;
`endif
    printable = (cur >= 8'h20) && (cur <= 8'h7E);
    erase     = (cur == 8'h08) || (cur == 8'h7F);
    room      = line_len < MAX;
    store     = !rst && (state == DECODE) && printable && room;
  end

  always_ff @(posedge clk) begin
    if (store) ram[line_len[AW-1:0]] <= ch;
  end

  assign line_rd_data = (line_rd_addr < MAX) ? ram[line_rd_addr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_get    <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      line_len  <= 8'h00;
      line_done <= 1'b0;
      idx       <= 2'd0;
      seq_len   <= 2'd0;
      cur       <= 8'h00;
    end else begin
      rx_get    <= 1'b0;
      tx_start  <= 1'b0;
      line_done <= 1'b0;
      // line_len keeps the final length for the line_done cycle, then clears
      if (line_done) line_len <= 8'h00;
      case (state)
        IDLE: begin
          if (!rx_empty) begin
            rx_get <= 1'b1;
            cur    <= rx_data;
            state  <= DECODE;
          end
        end
        DECODE: begin
          idx     <= 2'd0;
          seq_len <= 2'd0;
          state   <= EMIT;
          if (printable) begin
            seq_len <= 2'd1;
            if (room) begin
              line_len <= line_len + 8'd1;
              seq[0]   <= ch;
            end else begin
              seq[0]   <= 8'h07;
            end
          end else if (erase) begin
            if (line_len != 8'h00) begin
              line_len <= line_len - 8'd1;
              seq[0]   <= 8'h08;
              seq[1]   <= 8'h20;
              seq[2]   <= 8'h08;
              seq_len  <= 2'd3;
            end else begin
              state <= IDLE;
            end
          end else if (cur == 8'h0D) begin
            line_done <= 1'b1;
            seq[0]    <= 8'h0D;
            seq[1]    <= 8'h0A;
            seq_len   <= 2'd2;
          end else begin
            state <= IDLE;
          end
        end
        EMIT: begin
          if (!tx_busy) begin
            tx_data  <= seq[idx];
            tx_start <= 1'b1;
            state    <= WAIT_ACK;
          end
        end
        // transmitter raises busy one cycle late, so skip sampling it here
        WAIT_ACK: state <= WAIT_TX;
        WAIT_TX: begin
          if (!tx_busy) begin
            idx   <= idx + 2'd1;
            state <= (idx + 2'd1 == seq_len) ? IDLE : EMIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
